uart_receiver: RTL
==================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver for 8N1 frames, LSB first, idle-high line; the receive-side counterpart of the team's uart_transmitter.
- Oversamples the line at clock rate using a per-baud bit-period counter and samples mid-bit.
- Pushes received bytes into a 64-entry first-word-fall-through FIFO.
- The host drains the FIFO with read_enable.
- Exposes programmable-threshold fullness, framing-error and overrun indications.

Parameters:
- CLOCK_FREQUENCY, 50_000_000: clock rate in Hz, used to derive bit-period divisors.
- FIFO_DEPTH, 64: receive buffer entries. Must be a power of two; 64 is the supported value.

Ports:
- clock  input  1  system clock; the block's only clock.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  1  serial line, asynchronous to clock, idle high.
- read_enable  input  1  pops the FIFO head when buffer_empty=0.
- buffer_full_threshold  input  6  fill level at which buffer_full asserts; 0 encodes 64.
- baudrate_select  input  2  00=9600, 01=19200, 10=57600, 11=115200.
- data_out  output  8  FIFO head byte; valid while buffer_empty=0.
- buffer_empty  output  1  FIFO holds zero bytes.
- buffer_full  output  1  FIFO count >= effective threshold.
- frame_error  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte dropped because the FIFO was full.

Behaviour:
- Reset values: data_out=0, buffer_empty=1, buffer_full=0, frame_error=0, overrun=0.
- Reset clears the FIFO, counters and state, and sets synchronizer flops to 1. Reset mid-frame discards the partial byte.
- Input synchronizer: 2 flops on data_in. "line" below means the synchronized value.
- Divisor: DIV = CLOCK_FREQUENCY / baud, integer rounded to nearest.
- baudrate_select is latched on the IDLE->START transition. Changes mid-frame have no effect until the next frame.
- IDLE:
  - line==0: load counter with DIV/2-1, latch divisor, go to START.
- START:
  - Counter decrements each cycle.
  - At 0 with line==0: reload DIV-1, bit_index=0, go to DATA.
  - At 0 with line==1: glitch; go to IDLE, nothing recorded.
- DATA:
  - At counter 0: shift_reg[bit_index]=line, reload DIV-1.
  - bit_index==7: go to STOP; otherwise increment bit_index.
- STOP, at counter 0:
  - line==1: push shift_reg, go to IDLE.
  - line==0: pulse frame_error, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until line==1, then go to IDLE. A held-low break therefore yields exactly one frame_error.
- Push latency: the byte appears on data_out (buffer_empty falls) on the clock after the stop-bit sample cycle.
- FIFO:
  - 7-bit count, 6-bit wrap-around read and write pointers.
  - Pop only when read_enable=1 and count>0. read_enable while empty is ignored with no side effects.
  - Push when count<64, or when count==64 with a pop in the same cycle; in that case count stays 64.
  - Otherwise the byte is dropped and overrun pulses for one cycle. FIFO contents are untouched.
  - Simultaneous push and pop at count 0: the new byte is stored, and the pop is ignored because the FIFO was empty.
- buffer_full: threshold T (0 means 64); asserted when count >= T. Combinational from registered count and the input.
- Frame length is 10*DIV cycles nominal. Back-to-back frames are accepted because a new start edge is detected in IDLE right after the stop sample.

Decomposition:
- uart_package holds:
  - baudrate_t enum (B9600, B19200, B57600, B115200) with the encoding above.
  - Function baud_divisor(clock_frequency, baudrate_t).
  - Constants DATA_BITS=8 and FIFO_DEPTH_DEFAULT=64.
  - receiver_state_t enum (IDLE, START, DATA, STOP, WAIT_IDLE).
- Sub-module uart_receiver_fifo: synchronous FWFT FIFO with push, pop, head, count, and an overflow indication. The top level contains the synchronizer, FSM and bit counter.

Test Plan:
All scenarios use CLOCK_FREQUENCY=1_843_200, so DIV for select 11 = 16 and for select 00 = 192.
- Reset asserted mid-idle and mid-frame -> all outputs at reset values; no byte appears after release even if the frame tail continues.
- select=11, send 0xA5 -> buffer_empty falls 1 cycle after the stop sample with data_out=0xA5; one read_enable -> buffer_empty=1.
- select=11, line low for 5 cycles then high -> no push, no frame_error, FSM back in IDLE. A following valid 0x3C is received correctly.
- Frame 0x3C with stop bit low, held low 40 cycles -> single frame_error pulse, FIFO empty. Then line high and a valid 0x11 -> 0x11 received.
- threshold=4, send 4 bytes -> buffer_full rises with the 4th push. Continue to 64 with no reads; the 65th byte -> overrun pulse, count 64. Reading all 64 returns bytes in order; the 65th is absent.
- select=00, toggle baudrate_select to 11 mid-frame, send 0x5A -> 0x5A received at 9600 timing. Next frame uses 115200.

Source files
------------

// File: rtl/uart_receiver_pkg.sv
// Shared types and helpers for the 8N1 UART receiver: baud encodings, FSM states
// and the clock-to-baud divisor calculation.
package uart_package;

   typedef enum logic [1:0] {
      B9600   = 2'b00,
      B19200  = 2'b01,
      B57600  = 2'b10,
      B115200 = 2'b11
   } baudrate_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } receiver_state_t;

   localparam int DATA_BITS          = 8;
   localparam int FIFO_DEPTH_DEFAULT = 64;

   // Cycles per bit, rounded to the nearest integer.
   function automatic int unsigned baud_divisor(input int unsigned clock_frequency,
                                                input baudrate_t    baudrate);
      int unsigned rate;
      case (baudrate)
         B9600:   rate = 9600;
         B19200:  rate = 19200;
         B57600:  rate = 57600;
         default: rate = 115200;
      endcase
      return (clock_frequency + rate / 2) / rate;
   endfunction

endpackage

// File: rtl/uart_receiver_fifo.sv
// First-word-fall-through receive FIFO. A push into a full FIFO is accepted only
// when a pop happens in the same cycle; otherwise it is dropped and flagged.
module uart_receiver_fifo #(
   parameter int DEPTH   = 64,
   parameter int WIDTH   = 8,
   parameter int PTR_W   = $clog2(DEPTH),
   parameter int COUNT_W = $clog2(DEPTH) + 1
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_push,
   input  logic [WIDTH-1:0]   i_push_data,
   input  logic               i_pop,
   output logic [WIDTH-1:0]   o_head,
   output logic [COUNT_W-1:0] o_count,
   output logic               o_overflow
);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [COUNT_W-1:0] r_count;
   logic               r_overflow;
   logic               w_pop;
   logic               w_push;

   assign w_pop  = i_pop && (r_count != '0);
   assign w_push = i_push && ((r_count != COUNT_W'(DEPTH)) || w_pop);

   always_ff @(posedge i_clock) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_data;
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + COUNT_W'(1);
            2'b01:   r_count <= r_count - COUNT_W'(1);
            default: r_count <= r_count;
         endcase
         r_overflow <= i_push && !w_push;
      end
   end

   // Head is forced to zero while empty so the output is defined out of reset.
   assign o_head     = (r_count == '0) ? '0 : r_mem[r_rd_ptr];
   assign o_count    = r_count;
   assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop line synchronizer, mid-bit sampling FSM and a
// FWFT receive FIFO drained by the host.
module uart_receiver
   import uart_package::*;
#(
   parameter int unsigned CLOCK_FREQUENCY = 50_000_000,
   parameter int unsigned FIFO_DEPTH      = FIFO_DEPTH_DEFAULT
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            data_in,
   input  logic            read_enable,
   input  logic [5:0]      buffer_full_threshold,
   input  logic [1:0]      baudrate_select,
   output logic [7:0]      data_out,
   output logic            buffer_empty,
   output logic            buffer_full,
   output logic            frame_error,
   output logic            overrun,
   output receiver_state_t debug_state
);

   localparam int unsigned DIV_9600   = baud_divisor(CLOCK_FREQUENCY, B9600);
   localparam int unsigned DIV_19200  = baud_divisor(CLOCK_FREQUENCY, B19200);
   localparam int unsigned DIV_57600  = baud_divisor(CLOCK_FREQUENCY, B57600);
   localparam int unsigned DIV_115200 = baud_divisor(CLOCK_FREQUENCY, B115200);
   localparam int DIV_W   = $clog2(DIV_9600 + 1);
   localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]           r_sync;
   logic                 w_line;
   logic [DIV_W-1:0]     w_div_sel;
   logic [DIV_W-1:0]     r_divisor;
   logic [DIV_W-1:0]     r_count;
   receiver_state_t      r_state;
   logic [2:0]           r_bit_index;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_push_data;
   logic                 r_push;
   logic                 r_frame_error;
   logic [COUNT_W-1:0]   w_fifo_count;
   logic [COUNT_W-1:0]   w_threshold;

   assign w_line = r_sync[1];

   always_comb begin
      w_div_sel = DIV_W'(DIV_9600);
      case (baudrate_t'(baudrate_select))
         B19200:  w_div_sel = DIV_W'(DIV_19200);
         B57600:  w_div_sel = DIV_W'(DIV_57600);
         B115200: w_div_sel = DIV_W'(DIV_115200);
         default: w_div_sel = DIV_W'(DIV_9600);
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sync        <= 2'b11;
         r_state       <= IDLE;
         r_divisor     <= '0;
         r_count       <= '0;
         r_bit_index   <= '0;
         r_shift       <= '0;
         r_push_data   <= '0;
         r_push        <= 1'b0;
         r_frame_error <= 1'b0;
      end else begin
         r_sync        <= {r_sync[0], data_in};
         r_push        <= 1'b0;
         r_frame_error <= 1'b0;
         case (r_state)
            IDLE: begin
               // Half a bit period lands the start-bit check mid-bit.
               if (!w_line) begin
                  r_divisor <= w_div_sel;
                  r_count   <= (w_div_sel >> 1) - DIV_W'(1);
                  r_state   <= START;
               end
            end
            START: begin
               if (r_count == '0) begin
                  if (!w_line) begin
                     r_count     <= r_divisor - DIV_W'(1);
                     r_bit_index <= '0;
                     r_state     <= DATA;
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  r_count <= r_count - DIV_W'(1);
               end
            end
            DATA: begin
               if (r_count == '0) begin
                  r_shift[r_bit_index] <= w_line;
                  r_count              <= r_divisor - DIV_W'(1);
                  if (r_bit_index == 3'(DATA_BITS - 1)) r_state <= STOP;
                  else r_bit_index <= r_bit_index + 3'd1;
               end else begin
                  r_count <= r_count - DIV_W'(1);
               end
            end
            STOP: begin
               if (r_count == '0) begin
                  if (w_line) begin
                     r_push      <= 1'b1;
                     r_push_data <= r_shift;
                     r_state     <= IDLE;
                  end else begin
                     r_frame_error <= 1'b1;
                     r_state       <= WAIT_IDLE;
                  end
               end else begin
                  r_count <= r_count - DIV_W'(1);
               end
            end
            WAIT_IDLE: begin
               if (w_line) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Host handshake: data_out is valid while buffer_empty=0; a cycle with
   // read_enable=1 and buffer_empty=0 consumes it, read_enable on empty is ignored.
   uart_receiver_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .i_clock     (clock),
      .i_reset     (reset),
      .i_push      (r_push),
      .i_push_data (r_push_data),
      .i_pop       (read_enable),
      .o_head      (data_out),
      .o_count     (w_fifo_count),
      .o_overflow  (overrun)
   );

   assign w_threshold  = (buffer_full_threshold == '0) ? COUNT_W'(FIFO_DEPTH)
                                                       : COUNT_W'(buffer_full_threshold);
   assign buffer_empty = (w_fifo_count == '0);
   assign buffer_full  = (w_fifo_count >= w_threshold);
   assign frame_error  = r_frame_error;
   assign debug_state  = r_state;

endmodule
